// File: rtl/pm1_pkg.sv
// Shared definitions for the pm1 event FIFO.
// Holds the pm1 result-vector width, the bit position of each named output
// within the vector, the packed vector/event-word typedefs and a small
// saturating-counter helper.
package pm1_pkg;

    localparam int PM1_VEC_W = 13;

    // Bit position of each pm1 output inside the packed result vector.
    localparam int R_IDX  = 12;
    localparam int S_IDX  = 11;
    localparam int T_IDX  = 10;
    localparam int U_IDX  = 9;
    localparam int V_IDX  = 8;
    localparam int W_IDX  = 7;
    localparam int X_IDX  = 6;
    localparam int Y_IDX  = 5;
    localparam int Z_IDX  = 4;
    localparam int A0_IDX = 3;
    localparam int B0_IDX = 2;
    localparam int C0_IDX = 1;
    localparam int D0_IDX = 0;

    // Default timestamp width of an event word.
    localparam int PM1_TS_W = 8;

    typedef struct packed {
        logic r;
        logic s;
        logic t;
        logic u;
        logic v;
        logic w;
        logic x;
        logic y;
        logic z;
        logic a0;
        logic b0;
        logic c0;
        logic d0;
    } pm1_vec_t;

    // Event word layout: {timestamp, vector}, timestamp in the upper bits.
    typedef struct packed {
        logic [PM1_TS_W-1:0] ts;
        pm1_vec_t            vec;
    } pm1_evt_t;

    // Increment an 8-bit counter, holding at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] cnt);
        logic [7:0] res;
        if (cnt == 8'hFF) begin
            res = cnt;
        end else begin
            res = cnt + 8'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/pm1_sync_fifo.sv
// Synchronous FIFO holding pm1 event words.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (pointers/level only)
//   push_i     - push request; accepted when not full or when popping
//   pop_i      - pop request; ignored while empty
//   wdata_i    - word to push
//   push_ok_o  - push request was accepted this cycle
//   valid_o    - FIFO holds at least one word
//   rdata_o    - head word, zero while empty
//   level_o    - current occupancy
module pm1_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 21
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [W-1:0]           wdata_i,
    output logic                   push_ok_o,
    output logic                   valid_o,
    output logic [W-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             empty_s, full_s, pop_s, push_s;

    // Full/empty come from the occupancy count; pointers alone are ambiguous.
    always_comb begin
        empty_s  = (level_q == {LVL_W{1'b0}});
        full_s   = (level_q == FULL_LVL);
        pop_s    = pop_i && !empty_s;
        // A full FIFO still takes a push when the head leaves in the same cycle.
        push_s   = push_i && (!full_s || pop_s);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // DEPTH is a power of two, so natural pointer overflow is modulo DEPTH.
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            level_q  <= {LVL_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Head presentation, forced to zero while empty.
    always_comb begin
        push_ok_o = push_s;
        valid_o   = !empty_s;
        level_o   = level_q;
        if (empty_s) begin
            rdata_o = {W{1'b0}};
        end else begin
            rdata_o = mem_q[rd_ptr_q];
        end
    end

endmodule

// File: rtl/pm1_event_fifo.sv
// pm1 change-event recorder.
// Samples the pm1 result vector on in_valid cycles, raises an event when it
// differs from the previous sample (or on the first sample after reset),
// stamps it with a free-running timestamp and queues it in a FIFO.
// Events that find the FIFO full are dropped and counted.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   in_vec     - pm1 vector {r,s,t,u,v,w,x,y,z,a0,b0,c0,d0}
//   in_valid   - in_vec sampled this cycle
//   out_data   - head event {timestamp, vector}, zero when empty
//   out_valid  - FIFO non-empty
//   out_ready  - consumer takes the head
//   clr_ovf    - clear overflow flag and drop counter
//   ovf        - sticky drop indicator
//   drop_cnt   - saturating dropped-event count
//   level      - FIFO occupancy
module pm1_event_fifo
    import pm1_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TS_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PM1_VEC_W-1:0]      in_vec,
    input  logic                      in_valid,
    output logic [TS_W+PM1_VEC_W-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    input  logic                      clr_ovf,
    output logic                      ovf,
    output logic [7:0]                drop_cnt,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int EVT_W = TS_W + PM1_VEC_W;

    logic [TS_W-1:0]      ts_q, ts_d;
    logic [PM1_VEC_W-1:0] last_q, last_d;
    logic                 first_q, first_d;
    logic                 ovf_q, ovf_d;
    logic [7:0]           drop_cnt_q, drop_cnt_d;
    logic                 event_s, push_ok_s, drop_s;
    logic [EVT_W-1:0]     word_s;

    // Change detection and next-state for timestamp, history and overflow.
    always_comb begin
        // The reset cycle itself never produces an event.
        event_s    = in_valid && !rst && (first_q || (in_vec != last_q));
        drop_s     = event_s && !push_ok_s;
        word_s     = {ts_q, in_vec};
        ts_d       = ts_q + TS_W'(1);
        last_d     = last_q;
        first_d    = first_q;
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;
        // History tracks every valid sample, even ones whose event is dropped.
        if (in_valid) begin
            last_d  = in_vec;
            first_d = 1'b0;
        end else begin
            last_d  = last_q;
            first_d = first_q;
        end
        // A drop in the clearing cycle counts as the first drop after clear.
        if (clr_ovf) begin
            ovf_d      = drop_s;
            drop_cnt_d = drop_s ? 8'd1 : 8'd0;
        end else if (drop_s) begin
            ovf_d      = 1'b1;
            drop_cnt_d = sat_inc8(drop_cnt_q);
        end else begin
            ovf_d      = ovf_q;
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Timestamp, history and overflow state.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q       <= {TS_W{1'b0}};
            last_q     <= {PM1_VEC_W{1'b0}};
            first_q    <= 1'b1;
            ovf_q      <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            ts_q       <= ts_d;
            last_q     <= last_d;
            first_q    <= first_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    pm1_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (EVT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (event_s),
        .pop_i     (out_ready),
        .wdata_i   (word_s),
        .push_ok_o (push_ok_s),
        .valid_o   (out_valid),
        .rdata_o   (out_data),
        .level_o   (level)
    );

    // Status outputs straight from their registers.
    always_comb begin
        ovf      = ovf_q;
        drop_cnt = drop_cnt_q;
    end

endmodule

// File: tb/tb_pm1_event_fifo.sv
module tb_pm1_event_fifo;
    import pm1_pkg::*;

    logic        clk;
    logic        rst;
    logic [12:0] in_vec;
    logic        in_valid;
    logic [20:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        clr_ovf;
    logic        ovf;
    logic [7:0]  drop_cnt;
    logic [2:0]  level;

    int          n_vec;
    int          n_err;
    logic [7:0]  tb_ts;

    pm1_event_fifo #(.DEPTH(4), .TS_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_vec    (in_vec),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .clr_ovf   (clr_ovf),
        .ovf       (ovf),
        .drop_cnt  (drop_cnt),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; the bench timestamp model mirrors the free-running counter.
    task automatic cyc();
        @(posedge clk);
        if (rst) tb_ts = 8'd0;
        else     tb_ts = tb_ts + 8'd1;
        #1;
    endtask

    task automatic sample(input logic [12:0] v, output logic [7:0] ts);
        in_valid = 1'b1;
        in_vec   = v;
        ts       = tb_ts;
        cyc();
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] ew(input logic [7:0] ts, input logic [12:0] v);
        pm1_evt_t e;
        e.ts  = ts;
        e.vec = v;
        return 32'(e);
    endfunction

    logic [7:0]  ts_a;
    logic [7:0]  tsl [8];
    logic [12:0] vl  [8];
    logic [12:0] lastv;

    initial begin
        n_vec = 0; n_err = 0; tb_ts = 8'd0;
        rst = 1'b1; in_vec = 13'd0; in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
        cyc(); cyc();
        rst = 1'b0;

        // Reset state
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_level", 32'(level),     32'd0);
        chk("rst_ovf",   32'(ovf),       32'd0);
        chk("rst_drop",  32'(drop_cnt),  32'd0);

        // First sample at timestamp 5
        while (tb_ts != 8'd5) cyc();
        sample(13'h1ABC, ts_a);
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("first_data",  32'(out_data),  ew(8'd5, 13'h1ABC));
        chk("first_level", 32'(level),     32'd1);
        out_ready = 1'b1; cyc(); out_ready = 1'b0;
        chk("pop_level", 32'(level),     32'd0);
        chk("pop_valid", 32'(out_valid), 32'd0);
        chk("pop_data",  32'(out_data),  32'd0);

        // Repeated vector yields one event
        sample(13'h0042, ts_a);
        for (int i = 0; i < 3; i++) sample(13'h0042, tsl[0]);
        chk("rep_level", 32'(level),    32'd1);
        chk("rep_data",  32'(out_data), ew(ts_a, 13'h0042));
        out_ready = 1'b1; cyc(); out_ready = 1'b0;
        // Invalid cycle neither queues nor updates history
        in_vec = 13'h1FFF; cyc();
        chk("inval_level", 32'(level), 32'd0);
        sample(13'h0042, ts_a);
        chk("hist_level", 32'(level), 32'd0);

        // Overflow: six events into a depth-4 FIFO
        for (int i = 0; i < 6; i++) begin
            vl[i] = 13'h0100 + 13'(i);
            sample(vl[i], tsl[i]);
        end
        chk("ovf_level", 32'(level),    32'd4);
        chk("ovf_flag",  32'(ovf),      32'd1);
        chk("ovf_drop",  32'(drop_cnt), 32'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_ovf", 32'(out_data), ew(tsl[i], vl[i]));
            cyc();
        end
        out_ready = 1'b0;
        chk("drain_level", 32'(level), 32'd0);
        clr_ovf = 1'b1; cyc(); clr_ovf = 1'b0;
        chk("clr_ovf",  32'(ovf),      32'd0);
        chk("clr_drop", 32'(drop_cnt), 32'd0);

        // Push into full FIFO with simultaneous pop
        for (int i = 0; i < 4; i++) begin
            vl[i] = 13'h0200 + 13'(i);
            sample(vl[i], tsl[i]);
        end
        chk("full_level", 32'(level), 32'd4);
        out_ready = 1'b1;
        vl[4] = 13'h0300;
        sample(vl[4], tsl[4]);
        out_ready = 1'b0;
        chk("pp_level", 32'(level),    32'd4);
        chk("pp_ovf",   32'(ovf),      32'd0);
        chk("pp_drop",  32'(drop_cnt), 32'd0);
        chk("pp_head",  32'(out_data), ew(tsl[1], vl[1]));

        // Drops up to 7, then a drop coinciding with clear
        for (int i = 0; i < 7; i++) sample(13'h0400 + 13'(i), ts_a);
        chk("d7_drop", 32'(drop_cnt), 32'd7);
        clr_ovf = 1'b1;
        sample(13'h0500, ts_a);
        clr_ovf = 1'b0;
        chk("clrdrop_ovf",  32'(ovf),      32'd1);
        chk("clrdrop_cnt",  32'(drop_cnt), 32'd1);
        clr_ovf = 1'b1; cyc(); clr_ovf = 1'b0;
        chk("clr2_drop", 32'(drop_cnt), 32'd0);

        // Saturation at 255
        lastv = 13'h0000;
        for (int i = 0; i < 260; i++) begin
            lastv = (i % 2 == 0) ? 13'h0AAA : 13'h0555;
            sample(lastv, ts_a);
        end
        chk("sat_drop", 32'(drop_cnt), 32'd255);
        chk("sat_ovf",  32'(ovf),      32'd1);
        chk("sat_head", 32'(out_data), ew(tsl[1], vl[1]));

        // Reset mid-operation with level 3, in_valid held during reset
        out_ready = 1'b1; cyc(); out_ready = 1'b0;
        chk("pre_rst_level", 32'(level), 32'd3);
        rst = 1'b1; in_valid = 1'b1; in_vec = lastv;
        cyc();
        rst = 1'b0; in_valid = 1'b0;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_level", 32'(level),     32'd0);
        chk("mrst_drop",  32'(drop_cnt),  32'd0);
        chk("mrst_data",  32'(out_data),  32'd0);
        sample(lastv, ts_a);
        chk("rearm_level", 32'(level),    32'd1);
        chk("rearm_data",  32'(out_data), ew(ts_a, lastv));
        chk("rearm_ts0",   32'(ts_a),     32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pm1_event_fifo.md
PM1_EVENT_FIFO -- requirements
Module: pm1_event_fifo

Interface
REQ-001 Parameter: DEPTH, 4, FIFO entries; power of two, 2..16.
REQ-002 Parameter: TS_W, 8, timestamp width in bits.
REQ-003 The design SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_vec  input  13  pm1 result vector, packed {r,s,t,u,v,w,x,y,z,a0,b0,c0,d0}, r at bit 12.
REQ-007 in_valid  input  1  in_vec is sampled this cycle.
REQ-008 out_data  output  TS_W+13  head event word {timestamp, vector}.
REQ-009 out_valid  output  1  FIFO non-empty.
REQ-010 out_ready  input  1  consumer accepts head when out_valid=1.
REQ-011 clr_ovf  input  1  clears the overflow flag and drop counter.
REQ-012 ovf  output  1  sticky: at least one event dropped.
REQ-013 drop_cnt  output  8  saturating count of dropped events.
REQ-014 level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-015 The block SHALL compare in_vec against the last sampled vector on each in_valid=1 cycle and raise an event when they differ, or on the first in_valid=1 sample after reset.
REQ-016 The last-sampled register SHALL update on every in_valid=1 cycle, including when the event is dropped.
REQ-017 in_valid=0 cycles SHALL produce no event and leave the last-sampled register unchanged.
REQ-018 A free-running TS_W-bit timestamp SHALL increment each cycle, wrap from all-ones to 0, and be captured as the sampling-cycle value into the event word.
REQ-019 A push SHALL be accepted when level<DEPTH, or when level=DEPTH and a pop occurs in the same cycle.
REQ-020 A pop SHALL occur when out_valid=1 and out_ready=1; out_ready while empty has no effect.
REQ-021 An event SHALL become visible at out_valid/out_data exactly one cycle after its sampling cycle, in first-in first-out order.
REQ-022 Simultaneous push and pop SHALL leave level unchanged.
REQ-023 out_data SHALL be all zeros when out_valid=0.
REQ-024 A rejected push SHALL set ovf and increment drop_cnt, which saturates at 255.
REQ-025 clr_ovf=1 SHALL clear ovf and drop_cnt at the next edge; when a drop coincides with clr_ovf, the result SHALL be ovf=1 and drop_cnt=1.
REQ-026 Pointers SHALL wrap modulo DEPTH; full/empty SHALL be derived from level, never from pointer equality alone.

Reset
REQ-027 Reset SHALL force out_valid=0, out_data=0, level=0, ovf=0, drop_cnt=0, timestamp=0, read/write pointers=0, and last-sampled vector=0, and SHALL re-arm the first-sample flag.
REQ-028 Reset asserted mid-operation SHALL discard all queued events; in_valid during the reset cycle SHALL produce no event.
REQ-029 FIFO storage contents SHALL need no reset.

Structure
REQ-030 Shared package pm1_pkg SHALL hold PM1_VEC_W=13, per-output bit-index constants (R_IDX=12 .. D0_IDX=0), and the event-word struct typedef.
REQ-031 Storage and pointers SHALL live in one sub-module, pm1_sync_fifo; change detection, timestamp, and overflow logic SHALL stay in the top level.

Verification
REQ-032 Reset, then in_valid=1, in_vec=13'h1ABC at timestamp 5 -> next cycle out_valid=1, out_data={8'd5,13'h1ABC}.
REQ-033 Same vector 13'h0042 presented three consecutive valid cycles after the first -> exactly one event queued, level=1.
REQ-034 out_ready=0, six distinct vectors, DEPTH=4 -> level=4, ovf=1, drop_cnt=2; the four oldest events drain in order.
REQ-035 level=4, a new event arrives with out_ready=1 in the same cycle -> push accepted, level stays 4, ovf stays 0.
REQ-036 Drop in the same cycle as clr_ovf=1 with drop_cnt=7 -> ovf=1, drop_cnt=1.
REQ-037 rst pulsed with level=3 -> next cycle out_valid=0, level=0; the next valid sample of the previous vector produces an event.
